// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state encoding, default parameters and width helper for the FSK modulator.
// Also used by the receiver's reference-tone generator.
package fsk_pkg;
   typedef enum logic [1:0] {IDLE, TX, DONE} state_t;
   localparam int CODE_W     = 11;
   localparam int BIT_CYCLES = 16;
   localparam int HALF0      = 4;
   localparam int HALF1      = 2;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fsk_tone_gen.sv
// fsk_tone_gen: continuous-phase square-wave tone, half-period chosen by sel (1 -> HALF1, 0 -> HALF0).
// The wave is held at 0 with the phase cleared whenever en is low.
module fsk_tone_gen #(
   parameter int HALF0 = fsk_pkg::HALF0,
   parameter int HALF1 = fsk_pkg::HALF1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic sel,
   output logic wave
);
   import fsk_pkg::*;
   localparam int PW = clog2_min1(HALF0);
   logic [PW-1:0] phase_cnt;
   logic [PW-1:0] half_m1;
   assign half_m1 = sel ? PW'(HALF1 - 1) : PW'(HALF0 - 1);
   // >= lets a switch to the shorter tone toggle on the next clock instead of wrapping
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         phase_cnt <= '0;
         wave      <= 1'b0;
      end else if (!en) begin
         phase_cnt <= '0;
         wave      <= 1'b0;
      end else if (phase_cnt >= half_m1) begin
         phase_cnt <= '0;
         wave      <= ~wave;
      end else
         phase_cnt <= phase_cnt + PW'(1);
endmodule

// File: rtl/fsk_modulator.sv
// fsk_modulator: captures a codeword on a rising send edge and transmits it MSB-first
// as continuous-phase binary FSK, BIT_CYCLES clocks per bit.
module fsk_modulator #(
   parameter int WIDTH      = fsk_pkg::CODE_W,
   parameter int BIT_CYCLES = fsk_pkg::BIT_CYCLES,
   parameter int HALF0      = fsk_pkg::HALF0,
   parameter int HALF1      = fsk_pkg::HALF1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] code,
   input  logic             send,
   output logic             fsk_out,
   output logic             bit_out,
   output logic             busy,
   output logic             done,
   output logic             overrun
);
   import fsk_pkg::*;
   localparam int CW = clog2_min1(BIT_CYCLES);
   localparam int IW = clog2_min1(WIDTH);
   state_t           state;
   logic             send_d;
   logic             start;
   logic             bit_end;
   logic             last_bit;
   logic             tone_en;
   logic [WIDTH-2:0] shreg;
   logic [IW-1:0]    bit_idx;
   logic [CW-1:0]    cyc_cnt;
   assign start    = send & ~send_d;
   assign bit_end  = cyc_cnt == CW'(BIT_CYCLES - 1);
   assign last_bit = bit_idx == IW'(WIDTH - 1);
   // the tone is cleared on the frame's final clock so fsk_out is already 0 when done shows
   assign tone_en  = (state == TX) && !(bit_end && last_bit);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         send_d  <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
         cyc_cnt <= '0;
         bit_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         send_d <= send;
         done   <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  shreg   <= code[WIDTH-2:0];
                  bit_idx <= '0;
                  cyc_cnt <= '0;
                  bit_out <= code[WIDTH-1];
                  busy    <= 1'b1;
                  state   <= TX;
               end
            TX: begin
               if (start) overrun <= 1'b1;
               if (!bit_end)
                  cyc_cnt <= cyc_cnt + CW'(1);
               else if (last_bit) begin
                  cyc_cnt <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  bit_out <= 1'b0;
                  state   <= DONE;
               end else begin
                  cyc_cnt <= '0;
                  bit_idx <= bit_idx + IW'(1);
                  bit_out <= shreg[WIDTH-2];
                  shreg   <= {shreg[WIDTH-3:0], 1'b0};
               end
            end
            default: begin
               if (start) overrun <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   fsk_tone_gen #(.HALF0(HALF0), .HALF1(HALF1)) u_tone (
      .clk   (clk),
      .reset (reset),
      .en    (tone_en),
      .sel   (bit_out),
      .wave  (fsk_out)
   );
endmodule
